// File: rtl/dffram_dp.sv
// dffram_dp: flop-based dual-port RAM. Port A reads and writes, port B only reads.
// After reset, and after each CLR request, the block zero-fills every word
// (2^AW cycles). During that sweep INIT_DONE is low and both ports ignore requests.
//
// Parameters:
//   DW  data width, a multiple of 8 in the range 8..64 (default 32)
//   AW  address width, 1..12; the array holds 2^AW words (default 8)
// Ports:
//   CLK        clock; all state changes on its rising edge
//   RSTn       asynchronous active-low reset
//   CLR        in RUN, starts a new zero-fill sweep
//   INIT_DONE  high once the sweep has finished and the ports accept requests
//   EN_A/WE_A/A_A/DI_A  port A strobe, byte-lane write enables, address, write data
//   DO_A/VLD_A registered port A read data (old word) and its one-cycle valid pulse
//   EN_B/A_B   port B read strobe and address
//   DO_B/VLD_B registered port B read data and its one-cycle valid pulse
//
// Build option:
//   DFFRAM_DP_FWD_EN  when defined, a port B read of the word that port A writes in
//                     the same cycle returns the merged word (lanes written by A
//                     come from DI_A, the rest from the old word). When undefined,
//                     port B returns the old word and the forwarding mux is absent.
module dffram_dp #(
  parameter int DW = 32,
  parameter int AW = 8
) (
  input  logic            CLK,
  input  logic            RSTn,
  input  logic            CLR,
  output logic            INIT_DONE,
  input  logic            EN_A,
  input  logic [DW/8-1:0] WE_A,
  input  logic [AW-1:0]   A_A,
  input  logic [DW-1:0]   DI_A,
  output logic [DW-1:0]   DO_A,
  output logic            VLD_A,
  input  logic            EN_B,
  input  logic [AW-1:0]   A_B,
  output logic [DW-1:0]   DO_B,
  output logic            VLD_B
);

  localparam int NB = DW / 8;
  localparam int DEPTH = 1 << AW;
  localparam logic [AW-1:0] CNT_LAST = '1;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          init_done_q, init_done_d;
  logic [DW-1:0] do_a_q, do_a_d;
  logic [DW-1:0] do_b_q, do_b_d;
  logic          vld_a_q, vld_a_d;
  logic          vld_b_q, vld_b_d;

  logic [DW-1:0] mem_q [DEPTH];

  logic [DW-1:0] rd_a_s;
  logic [DW-1:0] rd_b_s;
  logic [DW-1:0] merge_a_s;
  logic [DW-1:0] rd_b_eff_s;
  logic          wr_en_s;
  logic [AW-1:0] wr_addr_s;
  logic [DW-1:0] wr_word_s;

  assign rd_a_s = mem_q[A_A];
  assign rd_b_s = mem_q[A_B];

  // Port A write word: enabled lanes from DI_A, the remaining lanes keep the old word.
  always_comb begin
    merge_a_s = rd_a_s;
    for (int i = 0; i < NB; i++) begin
      if (WE_A[i]) begin
        merge_a_s[8*i +: 8] = DI_A[8*i +: 8];
      end else begin
        merge_a_s[8*i +: 8] = rd_a_s[8*i +: 8];
      end
    end
  end

`ifdef DFFRAM_DP_FWD_EN
  // Same-cycle forwarding: a port B hit on the word port A is writing sees the merged word.
  always_comb begin
    rd_b_eff_s = rd_b_s;
    if ((state_q == ST_RUN) && EN_A && (|WE_A) && (A_A == A_B)) begin
      rd_b_eff_s = merge_a_s;
    end else begin
      rd_b_eff_s = rd_b_s;
    end
  end
`else
  assign rd_b_eff_s = rd_b_s;
`endif

  // Array write decode: zero-fill from the sweep counter in INIT, port A in RUN.
  always_comb begin
    wr_en_s   = 1'b0;
    wr_addr_s = cnt_q;
    wr_word_s = '0;
    case (state_q)
      ST_INIT: begin
        wr_en_s   = 1'b1;
        wr_addr_s = cnt_q;
        wr_word_s = '0;
      end
      ST_RUN: begin
        if (EN_A && (|WE_A)) begin
          wr_en_s   = 1'b1;
          wr_addr_s = A_A;
          wr_word_s = merge_a_s;
        end else begin
          wr_en_s   = 1'b0;
          wr_addr_s = A_A;
          wr_word_s = '0;
        end
      end
      default: begin
        wr_en_s   = 1'b0;
        wr_addr_s = cnt_q;
        wr_word_s = '0;
      end
    endcase
  end

  // Next-state logic for the sweep FSM and both read ports.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_done_d = init_done_q;
    do_a_d      = do_a_q;
    do_b_d      = do_b_q;
    vld_a_d     = 1'b0;
    vld_b_d     = 1'b0;
    case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + AW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d     = ST_RUN;
          init_done_d = 1'b1;
        end else begin
          state_d     = ST_INIT;
          init_done_d = 1'b0;
        end
      end
      ST_RUN: begin
        // CLR restarts the sweep, but any request seen in this cycle still completes.
        if (CLR) begin
          state_d     = ST_INIT;
          cnt_d       = '0;
          init_done_d = 1'b0;
        end else begin
          state_d     = ST_RUN;
          cnt_d       = cnt_q;
          init_done_d = 1'b1;
        end
        if (EN_A) begin
          do_a_d  = rd_a_s;
          vld_a_d = 1'b1;
        end else begin
          do_a_d  = do_a_q;
          vld_a_d = 1'b0;
        end
        if (EN_B) begin
          do_b_d  = rd_b_eff_s;
          vld_b_d = 1'b1;
        end else begin
          do_b_d  = do_b_q;
          vld_b_d = 1'b0;
        end
      end
      default: begin
        state_d     = ST_INIT;
        cnt_d       = '0;
        init_done_d = 1'b0;
      end
    endcase
  end

  // FSM, sweep counter and registered outputs, cleared asynchronously by RSTn.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
      do_a_q      <= '0;
      do_b_q      <= '0;
      vld_a_q     <= 1'b0;
      vld_b_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
      do_a_q      <= do_a_d;
      do_b_q      <= do_b_d;
      vld_a_q     <= vld_a_d;
      vld_b_q     <= vld_b_d;
    end
  end

  // Storage array; it has no reset, the sweep is the only thing that zeroes it.
  always_ff @(posedge CLK) begin
    if (wr_en_s) begin
      mem_q[wr_addr_s] <= wr_word_s;
    end
  end

  assign INIT_DONE = init_done_q;
  assign DO_A      = do_a_q;
  assign VLD_A     = vld_a_q;
  assign DO_B      = do_b_q;
  assign VLD_B     = vld_b_q;

endmodule

// File: tb/tb_dffram_dp.sv
module tb_dffram_dp;

  localparam int DW = 32;
  localparam int AW = 8;

  logic          CLK = 1'b0;
  logic          RSTn;
  logic          CLR;
  logic          INIT_DONE;
  logic          EN_A;
  logic [3:0]    WE_A;
  logic [7:0]    A_A;
  logic [31:0]   DI_A;
  logic [31:0]   DO_A;
  logic          VLD_A;
  logic          EN_B;
  logic [7:0]    A_B;
  logic [31:0]   DO_B;
  logic          VLD_B;

  int tests = 0;
  int fails = 0;

  logic [31:0] model [256];
  logic [31:0] exp_a [$];
  logic [31:0] exp_b [$];
  logic [31:0] hold_a;
  logic [31:0] hold_b;

  always #5 CLK = ~CLK;

  dffram_dp #(.DW(DW), .AW(AW)) dut (
    .CLK(CLK), .RSTn(RSTn), .CLR(CLR), .INIT_DONE(INIT_DONE),
    .EN_A(EN_A), .WE_A(WE_A), .A_A(A_A), .DI_A(DI_A), .DO_A(DO_A), .VLD_A(VLD_A),
    .EN_B(EN_B), .A_B(A_B), .DO_B(DO_B), .VLD_B(VLD_B)
  );

  task automatic idle_inputs();
    EN_A = 1'b0; WE_A = 4'h0; A_A = 8'h00; DI_A = 32'h0;
    EN_B = 1'b0; A_B = 8'h00; CLR = 1'b0;
  endtask

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic zero_model();
    for (int i = 0; i < 256; i++) model[i] = 32'h0;
  endtask

  // Drive one RUN-state request and push the bench's expected read data.
  task automatic drive(input logic ea, input logic [3:0] we, input logic [7:0] aa,
                       input logic [31:0] di, input logic eb, input logic [7:0] ab);
    logic [31:0] old;
    logic [31:0] mrg;
    EN_A = ea; WE_A = we; A_A = aa; DI_A = di; EN_B = eb; A_B = ab;
    old = model[aa];
    for (int i = 0; i < 4; i++) mrg[8*i +: 8] = we[i] ? di[8*i +: 8] : old[8*i +: 8];
    if (ea) exp_a.push_back(old);
    if (eb) begin
`ifdef DFFRAM_DP_FWD_EN
      if (ea && (aa == ab)) exp_b.push_back(mrg);
      else exp_b.push_back(model[ab]);
`else
      exp_b.push_back(model[ab]);
`endif
    end
    if (ea) model[aa] = mrg;
  endtask

  task automatic test_reset();
    int n;
    logic [31:0] e;
    logic [7:0] addrs [3];
    addrs[0] = 8'h00; addrs[1] = 8'h7F; addrs[2] = 8'hFF;
    RSTn = 1'b0;
    idle_inputs();
    repeat (3) step();
    tests++;
    if ({DO_A, DO_B, VLD_A, VLD_B, INIT_DONE} !== 67'h0) begin
      fails++;
      $display("FAIL reset_outputs: DO_A=%h DO_B=%h VLD_A=%b VLD_B=%b INIT_DONE=%b, expected all 0",
               DO_A, DO_B, VLD_A, VLD_B, INIT_DONE);
    end
    RSTn = 1'b1;
    n = 0;
    while (INIT_DONE !== 1'b1 && n < 400) begin
      step();
      n++;
    end
    tests++;
    if (n != 256) begin
      fails++;
      $display("FAIL reset_sweep_len: INIT_DONE rose after %0d cycles, expected 256", n);
    end
    zero_model();
    hold_a = 32'h0; hold_b = 32'h0;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 4'h0, addrs[k], 32'h0, 1'b1, addrs[k]);
      step();
      e = exp_a.pop_front();
      tests++;
      if (VLD_A !== 1'b1 || DO_A !== 32'h0 || DO_A !== e) begin
        fails++;
        $display("FAIL reset_read_a: addr=%h DO_A=%h VLD_A=%b, expected 00000000/1", addrs[k], DO_A, VLD_A);
      end
      e = exp_b.pop_front();
      tests++;
      if (VLD_B !== 1'b1 || DO_B !== 32'h0 || DO_B !== e) begin
        fails++;
        $display("FAIL reset_read_b: addr=%h DO_B=%h VLD_B=%b, expected 00000000/1", addrs[k], DO_B, VLD_B);
      end
      hold_a = 32'h0; hold_b = 32'h0;
    end
    idle_inputs();
  endtask

  task automatic test_read_before_write();
    logic [31:0] e;
    drive(1'b1, 4'hF, 8'h10, 32'h12345678, 1'b0, 8'h00);
    step();
    e = exp_a.pop_front();
    tests++;
    if (VLD_A !== 1'b1 || DO_A !== 32'h00000000 || DO_A !== e || VLD_B !== 1'b0) begin
      fails++;
      $display("FAIL rbw_first: DO_A=%h VLD_A=%b VLD_B=%b, expected 00000000/1/0", DO_A, VLD_A, VLD_B);
    end
    drive(1'b1, 4'h0, 8'h10, 32'h0, 1'b0, 8'h00);
    step();
    e = exp_a.pop_front();
    tests++;
    if (VLD_A !== 1'b1 || DO_A !== 32'h12345678 || DO_A !== e) begin
      fails++;
      $display("FAIL rbw_second: DO_A=%h VLD_A=%b, expected 12345678/1", DO_A, VLD_A);
    end
    hold_a = 32'h12345678;
    idle_inputs();
    step();
    tests++;
    if (VLD_A !== 1'b0 || DO_A !== hold_a) begin
      fails++;
      $display("FAIL rbw_pulse_end: DO_A=%h VLD_A=%b, expected %h/0", DO_A, VLD_A, hold_a);
    end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] e;
    drive(1'b1, 4'b0101, 8'h10, 32'hAABBCCDD, 1'b0, 8'h00);
    step();
    e = exp_a.pop_front();
    tests++;
    if (VLD_A !== 1'b1 || DO_A !== e) begin
      fails++;
      $display("FAIL lanes_write: DO_A=%h VLD_A=%b, expected %h/1", DO_A, VLD_A, e);
    end
    drive(1'b1, 4'h0, 8'h10, 32'h0, 1'b0, 8'h00);
    step();
    e = exp_a.pop_front();
    tests++;
    if (VLD_A !== 1'b1 || DO_A !== 32'h12BB56DD || DO_A !== e) begin
      fails++;
      $display("FAIL lanes_merge: DO_A=%h VLD_A=%b, expected 12BB56DD/1", DO_A, VLD_A);
    end
    hold_a = DO_A;
    idle_inputs();
  endtask

  task automatic test_same_cycle();
    logic [31:0] e;
    logic [31:0] want_b;
`ifdef DFFRAM_DP_FWD_EN
    want_b = 32'h1111FFFF;
`else
    want_b = 32'h11111111;
`endif
    drive(1'b1, 4'hF, 8'h20, 32'h11111111, 1'b0, 8'h00);
    step();
    e = exp_a.pop_front();
    drive(1'b1, 4'b0011, 8'h20, 32'hFFFFFFFF, 1'b1, 8'h20);
    step();
    e = exp_a.pop_front();
    tests++;
    if (VLD_A !== 1'b1 || DO_A !== 32'h11111111 || DO_A !== e) begin
      fails++;
      $display("FAIL same_cycle_a: DO_A=%h VLD_A=%b, expected 11111111/1", DO_A, VLD_A);
    end
    e = exp_b.pop_front();
    tests++;
    if (VLD_B !== 1'b1 || DO_B !== want_b || DO_B !== e) begin
      fails++;
      $display("FAIL same_cycle_b: DO_B=%h VLD_B=%b, expected %h/1", DO_B, VLD_B, want_b);
    end
    drive(1'b1, 4'h0, 8'h20, 32'h0, 1'b1, 8'h20);
    step();
    e = exp_a.pop_front();
    void'(exp_b.pop_front());
    tests++;
    if (VLD_A !== 1'b1 || VLD_B !== 1'b1 || DO_A !== 32'h1111FFFF || DO_B !== 32'h1111FFFF || DO_A !== e) begin
      fails++;
      $display("FAIL both_ports_same_addr: DO_A=%h DO_B=%h, expected 1111FFFF on both", DO_A, DO_B);
    end
    hold_a = 32'h1111FFFF; hold_b = 32'h1111FFFF;
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    logic ea, eb;
    logic [31:0] e;
    for (int c = 0; c < 300; c++) begin
      ea = (c < 20) ? 1'b1 : ($urandom_range(0, 3) != 0);
      eb = (c < 20) ? 1'b1 : ($urandom_range(0, 3) != 0);
      drive(ea, 4'($urandom_range(0, 15)), 8'($urandom_range(0, 15)), $urandom,
            eb, 8'($urandom_range(0, 15)));
      step();
      if (ea) begin
        e = exp_a.pop_front();
        hold_a = e;
      end else begin
        e = hold_a;
      end
      tests++;
      if (VLD_A !== ea || DO_A !== e) begin
        fails++;
        $display("FAIL b2b_a cycle %0d: DO_A=%h VLD_A=%b, expected %h/%b", c, DO_A, VLD_A, e, ea);
      end
      if (eb) begin
        e = exp_b.pop_front();
        hold_b = e;
      end else begin
        e = hold_b;
      end
      tests++;
      if (VLD_B !== eb || DO_B !== e) begin
        fails++;
        $display("FAIL b2b_b cycle %0d: DO_B=%h VLD_B=%b, expected %h/%b", c, DO_B, VLD_B, e, eb);
      end
    end
    idle_inputs();
    step();
  endtask

  task automatic test_clr();
    logic [31:0] e;
    int n;
    logic done;
    drive(1'b1, 4'hF, 8'h33, 32'hCAFEF00D, 1'b0, 8'h00);
    step();
    void'(exp_a.pop_front());
    drive(1'b1, 4'h0, 8'h33, 32'h0, 1'b1, 8'h33);
    CLR = 1'b1;
    step();
    e = exp_a.pop_front();
    tests++;
    if (VLD_A !== 1'b1 || DO_A !== 32'hCAFEF00D || DO_A !== e || INIT_DONE !== 1'b0) begin
      fails++;
      $display("FAIL clr_request_completes: DO_A=%h VLD_A=%b INIT_DONE=%b, expected CAFEF00D/1/0",
               DO_A, VLD_A, INIT_DONE);
    end
    e = exp_b.pop_front();
    tests++;
    if (VLD_B !== 1'b1 || DO_B !== e) begin
      fails++;
      $display("FAIL clr_request_b: DO_B=%h VLD_B=%b, expected %h/1", DO_B, VLD_B, e);
    end
    hold_a = 32'hCAFEF00D; hold_b = e;
    n = 1;
    done = 1'b0;
    while (!done && n < 400) begin
      CLR = 1'b0;
      EN_A = 1'b1; WE_A = 4'hF; A_A = 8'($urandom_range(0, 255)); DI_A = 32'hFFFFFFFF;
      EN_B = 1'b1; A_B = 8'($urandom_range(0, 255));
      step();
      tests++;
      if (VLD_A !== 1'b0 || VLD_B !== 1'b0 || DO_A !== hold_a || DO_B !== hold_b) begin
        fails++;
        $display("FAIL clr_ignored: n=%0d DO_A=%h DO_B=%h VLD_A=%b VLD_B=%b, expected %h/%h/0/0",
                 n, DO_A, DO_B, VLD_A, VLD_B, hold_a, hold_b);
      end
      if (INIT_DONE === 1'b1) done = 1'b1;
      else n++;
    end
    tests++;
    if (n != 256) begin
      fails++;
      $display("FAIL clr_sweep_len: INIT_DONE low for %0d cycles, expected 256", n);
    end
    zero_model();
    for (int k = 0; k < 4; k++) begin
      logic [7:0] ad;
      ad = (k == 0) ? 8'h10 : (k == 1) ? 8'h33 : 8'($urandom_range(0, 255));
      drive(1'b1, 4'h0, ad, 32'h0, 1'b1, ad);
      step();
      e = exp_a.pop_front();
      void'(exp_b.pop_front());
      tests++;
      if (VLD_A !== 1'b1 || VLD_B !== 1'b1 || DO_A !== 32'h0 || DO_B !== 32'h0 || DO_A !== e) begin
        fails++;
        $display("FAIL clr_zeroed: addr=%h DO_A=%h DO_B=%h, expected 00000000", ad, DO_A, DO_B);
      end
    end
    hold_a = 32'h0; hold_b = 32'h0;
    idle_inputs();
  endtask

  task automatic test_reset_mid_sweep();
    logic [31:0] e;
    int n;
    drive(1'b1, 4'hF, 8'h05, 32'hDEADBEEF, 1'b0, 8'h00);
    step();
    void'(exp_a.pop_front());
    drive(1'b1, 4'h0, 8'h05, 32'h0, 1'b1, 8'h05);
    step();
    void'(exp_a.pop_front());
    e = exp_b.pop_front();
    idle_inputs();
    CLR = 1'b1;
    step();
    CLR = 1'b0;
    repeat (100) step();
    tests++;
    if (DO_A !== 32'hDEADBEEF || DO_B !== e || INIT_DONE !== 1'b0) begin
      fails++;
      $display("FAIL mid_sweep_hold: DO_A=%h DO_B=%h INIT_DONE=%b, expected DEADBEEF/%h/0",
               DO_A, DO_B, INIT_DONE, e);
    end
    RSTn = 1'b0;
    #1;
    tests++;
    if ({DO_A, DO_B, VLD_A, VLD_B, INIT_DONE} !== 67'h0) begin
      fails++;
      $display("FAIL mid_sweep_reset: DO_A=%h DO_B=%h INIT_DONE=%b, expected all 0 at once",
               DO_A, DO_B, INIT_DONE);
    end
    step();
    RSTn = 1'b1;
    n = 0;
    while (INIT_DONE !== 1'b1 && n < 400) begin
      step();
      n++;
    end
    tests++;
    if (n != 256) begin
      fails++;
      $display("FAIL mid_sweep_restart: INIT_DONE rose after %0d cycles, expected 256", n);
    end
    zero_model();
    drive(1'b1, 4'h0, 8'h05, 32'h0, 1'b1, 8'hFF);
    step();
    e = exp_a.pop_front();
    void'(exp_b.pop_front());
    tests++;
    if (VLD_A !== 1'b1 || VLD_B !== 1'b1 || DO_A !== 32'h0 || DO_B !== 32'h0 || DO_A !== e) begin
      fails++;
      $display("FAIL mid_sweep_zeroed: DO_A=%h DO_B=%h, expected 00000000", DO_A, DO_B);
    end
    idle_inputs();
  endtask

  initial begin
    RSTn = 1'b0;
    idle_inputs();
    hold_a = 32'h0;
    hold_b = 32'h0;
    zero_model();
    test_reset();
    test_read_before_write();
    test_byte_lanes();
    test_same_cycle();
    test_back_to_back();
    test_clr();
    test_reset_mid_sweep();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
